// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide, fixed 34-cycle latency, flushable.
// Rev 1.0
`default_nettype none

module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [4:0]        cnt;
  logic [2*XLEN-1:0] work;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_q;
  logic              a_neg, b_neg, div_zero, ovf;

  // Operand decode, only consumed in IDLE
  logic            a_sgn, b_sgn, a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
  assign b_sgn    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign a_neg_in = a_sgn && a_i[XLEN-1];
  assign b_neg_in = b_sgn && b_i[XLEN-1];
  assign a_mag    = a_neg_in ? -a_i : a_i;
  assign b_mag    = b_neg_in ? -b_i : b_i;

  // One shift-add step (LSB-first) and one restoring-division step (MSB-first)
  logic [XLEN:0]     sum, trial, diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  assign sum      = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign mul_step = work[0] ? {sum, work[XLEN-1:1]} : {1'b0, work[2*XLEN-1:1]};
  assign trial    = work[2*XLEN-1:XLEN-1];
  assign diff     = trial - {1'b0, opnd};
  // diff[XLEN] is the borrow: set exactly when the trial remainder is below the divisor
  assign div_step = diff[XLEN] ? {trial[XLEN-1:0], work[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],  work[XLEN-2:0], 1'b1};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = CALC;
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Final sign correction and special-case selection
  logic            neg;
  logic [XLEN-1:0] hi, lo, mulh_neg, fix_result;

  assign neg      = a_neg ^ b_neg;
  assign hi       = work[2*XLEN-1:XLEN];
  assign lo       = work[XLEN-1:0];
  assign mulh_neg = ~hi + {{(XLEN-1){1'b0}}, (lo == '0)};

  always_comb begin
    fix_result = lo;
    case (op_q)
      3'b001, 3'b010, 3'b011: fix_result = neg ? mulh_neg : hi;
      3'b100, 3'b101: begin
        if (div_zero)  fix_result = '1;
        else if (ovf)  fix_result = {1'b1, {(XLEN-1){1'b0}}};
        else if (neg)  fix_result = -lo;
        else           fix_result = lo;
      end
      // A zero divisor leaves the dividend magnitude as remainder, so the sign fix restores a
      3'b110, 3'b111: begin
        if (ovf)        fix_result = '0;
        else if (a_neg) fix_result = -hi;
        else            fix_result = hi;
      end
      default: fix_result = lo;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      work     <= '0;
      opnd     <= '0;
      op_q     <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      busy_o <= (state_nx != IDLE);
      done_o <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q     <= op_i;
            a_neg    <= a_neg_in;
            b_neg    <= b_neg_in;
            div_zero <= (b_i == '0);
            ovf      <= (op_i == 3'b100 || op_i == 3'b110) &&
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
            work     <= {{XLEN{1'b0}}, a_mag};
            opnd     <= b_mag;
            cnt      <= '0;
          end
        end
        CALC: begin
          cnt  <= cnt + 5'd1;
          work <= op_q[2] ? div_step : mul_step;
        end
        FIX: begin
          if (!flush_i) result_o <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
